synth_ctrl_regs: RTL and testbench
==================================

SYNTH_CTRL_REGS -- requirements
Module: synth_ctrl_regs

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, range 1..16: number of voice register banks.
REQ-002 SHALL have parameter ADDR_W, default 7: Avalon word-address width; 32 + 4*NUM_VOICES <= 2**ADDR_W is checked at elaboration.
REQ-003 SHALL have port CLK  in  1  clock.
REQ-004 SHALL have port RESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports AVL_ADDR in ADDR_W, AVL_BYTE_EN in 4, AVL_READ in 1, AVL_WRITE in 1, AVL_CS in 1, AVL_WRITEDATA in 32: Avalon-MM slave request.
REQ-006 SHALL have ports AVL_READDATA out 32 and AVL_READDATAVALID out 1: registered read response.
REQ-007 SHALL have port SAMPLE_TICK  in  1  one-cycle audio-sample strobe that gates commits.
REQ-008 SHALL have global outputs SHAPE1/SHAPE0 (2 each), ATTACK/DECAY/SUSTAIN/RLEASE (16 each), GLIDE_EN (1), GLIDE_RATE (25), ARP_EN (1), ARP_TIME (16), PINGPONG_EN (1), PANNING (16).
REQ-009 SHALL have per-voice packed-array outputs KEY [NUM_VOICES] x 1, FREQ [NUM_VOICES] x 7, AMP1 [NUM_VOICES] x 16, AMP0 [NUM_VOICES] x 16.
REQ-010 SHALL have output COMMIT_PENDING  1  high while a commit request awaits SAMPLE_TICK.

Function
REQ-011 Register map SHALL be: words 0-11 the globals, in REQ-008 order; 12 COMMIT; 13 STATUS; 14 VERSION (read-only constant); voice v at 32+4v: +0 KEY[0], +1 FREQ[6:0], +2 AMP1[15:0], +3 AMP0[15:0].
REQ-012 A write SHALL occur when AVL_CS & AVL_WRITE; each byte lane is updated only where AVL_BYTE_EN is set; bits beyond the field width are discarded.
REQ-013 A read SHALL occur when AVL_CS & AVL_READ; AVL_READDATA SHALL be registered and AVL_READDATAVALID asserted exactly one cycle after the request.
REQ-014 Reads SHALL return the shadow value, zero-extended, for registers 0-11 and voice registers; unmapped or out-of-range addresses SHALL read 0 and ignore writes.
REQ-015 When no read is issued, AVL_READDATA SHALL hold 0 and AVL_READDATAVALID SHALL be 0; read data is never X.
REQ-016 Writes to registers 0-11 and voice registers SHALL update the shadow copy only; the active copy drives the outputs.
REQ-017 A write with bit 0 = 1 to COMMIT (byte lane 0 enabled) SHALL set pending; a repeat write while pending SHALL leave pending set, with no queueing.
REQ-018 On the first SAMPLE_TICK with pending=1, all shadow registers SHALL be copied atomically to active in one cycle; pending SHALL clear and STATUS.done SHALL set.
REQ-019 A shadow write coinciding with the commit cycle SHALL not be included; active gets the pre-write shadow value, and the new value remains in shadow.
REQ-020 A COMMIT write coinciding with SAMPLE_TICK while pending=0 SHALL set pending and commit at the next tick, not the current one.
REQ-021 STATUS SHALL read {30'b0, done, pending}; a write of 1 to bit 1 SHALL clear done; write-1-clear and a commit-set in the same cycle SHALL resolve to set.
REQ-022 COMMIT SHALL read 0; VERSION SHALL read {16'h0002, NUM_VOICES[15:0]}.
REQ-023 Simultaneous read and write to the same address SHALL return the pre-write value.

Reset
REQ-024 RESET SHALL clear all shadow and active registers, pending, done, AVL_READDATA and AVL_READDATAVALID to 0; every output is therefore 0 in the cycle after reset.
REQ-025 Reset asserted with a commit pending SHALL drop the commit; no partial copy occurs.

Configuration
REQ-026 Macro SYNTH_CTRL_SHADOW_EN defined: behaviour is per REQ-016..REQ-021.
REQ-027 Macro SYNTH_CTRL_SHADOW_EN undefined: no shadow storage; writes update active registers directly, taking effect at the next clock; COMMIT writes are ignored; COMMIT_PENDING is tied to 0; STATUS reads 0.

Structure
REQ-028 Package synth_ctrl_pkg SHALL hold the register address constants, the voice stride and field offsets, field-width localparams, the VERSION constant, and a voice_regs_t struct (key, freq, amp1, amp0).
REQ-029 Sub-module synth_voice_regbank SHALL hold one voice's shadow and active registers, byte-enable write logic and commit copy; it is instantiated NUM_VOICES times by generate.

Verification
REQ-030 Reset, then read all addresses 0-63 -> every read returns 0 except VERSION = 0x00020008; READDATAVALID one cycle after each read.
REQ-031 Write ATTACK=0x1234 with BYTE_EN=4'b0001 -> shadow reads 0x0034, ATTACK output stays 0; COMMIT=1, then SAMPLE_TICK -> ATTACK = 0x0034 next cycle, STATUS = 0x2.
REQ-032 Write voice 3 FREQ=0x45, COMMIT, and in the tick cycle write voice 3 FREQ=0x50 -> FREQ[3] = 0x45; after a second COMMIT plus tick, FREQ[3] = 0x50.
REQ-033 Set pending, assert RESET before any tick -> COMMIT_PENDING = 0; a later tick leaves all outputs 0.
REQ-034 Read address 31 and address 32+4*NUM_VOICES -> both return 0; writes to them change no readback.
REQ-035 Build without SYNTH_CTRL_SHADOW_EN, write KEY voice 0 = 1 -> KEY[0] = 1 the following cycle without any SAMPLE_TICK; STATUS reads 0.

Source files
------------

// File: rtl/synth_ctrl_pkg.sv
// Register map, field widths and shared types for the synth control register file.
package synth_ctrl_pkg;

   localparam int REG_SHAPE1      = 0;
   localparam int REG_SHAPE0      = 1;
   localparam int REG_ATTACK      = 2;
   localparam int REG_DECAY       = 3;
   localparam int REG_SUSTAIN     = 4;
   localparam int REG_RLEASE      = 5;
   localparam int REG_GLIDE_EN    = 6;
   localparam int REG_GLIDE_RATE  = 7;
   localparam int REG_ARP_EN      = 8;
   localparam int REG_ARP_TIME    = 9;
   localparam int REG_PINGPONG_EN = 10;
   localparam int REG_PANNING     = 11;
   localparam int REG_COMMIT      = 12;
   localparam int REG_STATUS      = 13;
   localparam int REG_VERSION     = 14;

   localparam int VOICE_BASE   = 32;
   localparam int VOICE_STRIDE = 4;
   localparam int VOFF_KEY     = 0;
   localparam int VOFF_FREQ    = 1;
   localparam int VOFF_AMP1    = 2;
   localparam int VOFF_AMP0    = 3;

   localparam int SHAPE_W      = 2;
   localparam int ENV_W        = 16;
   localparam int GLIDE_RATE_W = 25;
   localparam int ARP_TIME_W   = 16;
   localparam int PAN_W        = 16;
   localparam int KEY_W        = 1;
   localparam int FREQ_W       = 7;
   localparam int AMP_W        = 16;

   localparam logic [15:0] VERSION_HI = 16'h0002;

   typedef struct packed {
      logic [KEY_W-1:0]  key;
      logic [FREQ_W-1:0] freq;
      logic [AMP_W-1:0]  amp1;
      logic [AMP_W-1:0]  amp0;
   } voice_regs_t;

   typedef struct packed {
      logic [SHAPE_W-1:0]      shape1;
      logic [SHAPE_W-1:0]      shape0;
      logic [ENV_W-1:0]        attack;
      logic [ENV_W-1:0]        decay;
      logic [ENV_W-1:0]        sustain;
      logic [ENV_W-1:0]        rlease;
      logic                    glide_en;
      logic [GLIDE_RATE_W-1:0] glide_rate;
      logic                    arp_en;
      logic [ARP_TIME_W-1:0]   arp_time;
      logic                    pingpong_en;
      logic [PAN_W-1:0]        panning;
   } glob_regs_t;

   // Byte-lane merge; callers truncate the result to the field width.
   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/synth_ctrl_regs_if.sv
// Avalon-MM slave request/response bundle for synth_ctrl_regs.
interface synth_ctrl_regs_if #(
   parameter int ADDR_W = 7
);
   logic [ADDR_W-1:0] AVL_ADDR;
   logic [3:0]        AVL_BYTE_EN;
   logic              AVL_READ;
   logic              AVL_WRITE;
   logic              AVL_CS;
   logic [31:0]       AVL_WRITEDATA;
   logic [31:0]       AVL_READDATA;
   logic              AVL_READDATAVALID;

   modport master (
      output AVL_ADDR, AVL_BYTE_EN, AVL_READ, AVL_WRITE, AVL_CS, AVL_WRITEDATA,
      input  AVL_READDATA, AVL_READDATAVALID
   );

   modport slave (
      input  AVL_ADDR, AVL_BYTE_EN, AVL_READ, AVL_WRITE, AVL_CS, AVL_WRITEDATA,
      output AVL_READDATA, AVL_READDATAVALID
   );
endinterface

// File: rtl/synth_voice_regbank.sv
// One voice's register bank: byte-enable writes land in shadow, commit copies shadow to active.
// Without SYNTH_CTRL_SHADOW_EN the written copy is the active copy and commit is ignored.
module synth_voice_regbank
   import synth_ctrl_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        wr_en,
   input  logic [1:0]  wr_off,
   input  logic [31:0] wr_dat,
   input  logic [3:0]  byte_en,
   input  logic        commit,
   output voice_regs_t shadow,
   output voice_regs_t active
);

   voice_regs_t sh_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sh_q <= '0;
      end else if (wr_en) begin
         case (int'(wr_off))
            VOFF_KEY:  sh_q.key  <= KEY_W'(be_merge(32'(sh_q.key), wr_dat, byte_en));
            VOFF_FREQ: sh_q.freq <= FREQ_W'(be_merge(32'(sh_q.freq), wr_dat, byte_en));
            VOFF_AMP1: sh_q.amp1 <= AMP_W'(be_merge(32'(sh_q.amp1), wr_dat, byte_en));
            VOFF_AMP0: sh_q.amp0 <= AMP_W'(be_merge(32'(sh_q.amp0), wr_dat, byte_en));
            default:   ;
         endcase
      end
   end

   assign shadow = sh_q;

`ifdef SYNTH_CTRL_SHADOW_EN
   voice_regs_t act_q;

   // Nonblocking copy picks up the pre-write shadow when a write lands in the commit cycle.
   always_ff @(posedge CLK) begin
      if (RESET)
         act_q <= '0;
      else if (commit)
         act_q <= sh_q;
   end

   assign active = act_q;
`else
   logic unused_commit;
   assign unused_commit = commit;
   assign active        = sh_q;
`endif

endmodule

// File: rtl/synth_ctrl_regs.sv
// Synth control registers: Avalon-MM slave, read data registered one cycle after the request, no wait states.
// Shadow/active banking with SAMPLE_TICK-gated commit only when SYNTH_CTRL_SHADOW_EN is defined.
module synth_ctrl_regs
   import synth_ctrl_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int ADDR_W     = 7
) (
   input  logic                              CLK,
   input  logic                              RESET,
   synth_ctrl_regs_if.slave                  avl,
   input  logic                              SAMPLE_TICK,
   output logic [SHAPE_W-1:0]                SHAPE1,
   output logic [SHAPE_W-1:0]                SHAPE0,
   output logic [ENV_W-1:0]                  ATTACK,
   output logic [ENV_W-1:0]                  DECAY,
   output logic [ENV_W-1:0]                  SUSTAIN,
   output logic [ENV_W-1:0]                  RLEASE,
   output logic                              GLIDE_EN,
   output logic [GLIDE_RATE_W-1:0]           GLIDE_RATE,
   output logic                              ARP_EN,
   output logic [ARP_TIME_W-1:0]             ARP_TIME,
   output logic                              PINGPONG_EN,
   output logic [PAN_W-1:0]                  PANNING,
   output logic [NUM_VOICES-1:0]             KEY,
   output logic [NUM_VOICES-1:0][FREQ_W-1:0] FREQ,
   output logic [NUM_VOICES-1:0][AMP_W-1:0]  AMP1,
   output logic [NUM_VOICES-1:0][AMP_W-1:0]  AMP0,
   output logic                              COMMIT_PENDING
);

   if (NUM_VOICES < 1 || NUM_VOICES > 16) begin : g_bad_num_voices
      $error("synth_ctrl_regs: NUM_VOICES must be 1..16");
   end
   if (VOICE_BASE + VOICE_STRIDE * NUM_VOICES > 2 ** ADDR_W) begin : g_bad_addr_w
      $error("synth_ctrl_regs: ADDR_W too small for NUM_VOICES");
   end

   localparam logic [31:0] VERSION = {VERSION_HI, 16'(NUM_VOICES)};

   logic        wr;
   logic        rd;
   logic [31:0] addr32;
   logic [31:0] vrel;
   logic        in_voice;
   logic [31:0] wdat;
   logic [3:0]  be;

   assign wr       = avl.AVL_CS & avl.AVL_WRITE;
   assign rd       = avl.AVL_CS & avl.AVL_READ;
   assign addr32   = 32'(avl.AVL_ADDR);
   assign vrel     = addr32 - 32'(VOICE_BASE);
   assign in_voice = (addr32 >= 32'(VOICE_BASE)) &&
                     (addr32 < 32'(VOICE_BASE + VOICE_STRIDE * NUM_VOICES));
   assign wdat     = avl.AVL_WRITEDATA;
   assign be       = avl.AVL_BYTE_EN;

   glob_regs_t  glob_q;
   glob_regs_t  glob_act;
   logic        commit;
   logic [31:0] status;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         glob_q <= '0;
      end else if (wr) begin
         case (addr32)
            REG_SHAPE1:      glob_q.shape1      <= SHAPE_W'(be_merge(32'(glob_q.shape1), wdat, be));
            REG_SHAPE0:      glob_q.shape0      <= SHAPE_W'(be_merge(32'(glob_q.shape0), wdat, be));
            REG_ATTACK:      glob_q.attack      <= ENV_W'(be_merge(32'(glob_q.attack), wdat, be));
            REG_DECAY:       glob_q.decay       <= ENV_W'(be_merge(32'(glob_q.decay), wdat, be));
            REG_SUSTAIN:     glob_q.sustain     <= ENV_W'(be_merge(32'(glob_q.sustain), wdat, be));
            REG_RLEASE:      glob_q.rlease      <= ENV_W'(be_merge(32'(glob_q.rlease), wdat, be));
            REG_GLIDE_EN:    glob_q.glide_en    <= 1'(be_merge(32'(glob_q.glide_en), wdat, be));
            REG_GLIDE_RATE:  glob_q.glide_rate  <= GLIDE_RATE_W'(be_merge(32'(glob_q.glide_rate), wdat, be));
            REG_ARP_EN:      glob_q.arp_en      <= 1'(be_merge(32'(glob_q.arp_en), wdat, be));
            REG_ARP_TIME:    glob_q.arp_time    <= ARP_TIME_W'(be_merge(32'(glob_q.arp_time), wdat, be));
            REG_PINGPONG_EN: glob_q.pingpong_en <= 1'(be_merge(32'(glob_q.pingpong_en), wdat, be));
            REG_PANNING:     glob_q.panning     <= PAN_W'(be_merge(32'(glob_q.panning), wdat, be));
            default:         ;
         endcase
      end
   end

`ifdef SYNTH_CTRL_SHADOW_EN
   logic pending_q;
   logic done_q;
   logic commit_wr;
   logic done_clr;

   assign commit    = SAMPLE_TICK & pending_q;
   assign commit_wr = wr && (addr32 == REG_COMMIT) && be[0] && wdat[0];
   assign done_clr  = wr && (addr32 == REG_STATUS) && be[0] && wdat[1];

   // A COMMIT write in a tick cycle arms the next tick, never the current one.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pending_q <= 1'b0;
         done_q    <= 1'b0;
         glob_act  <= '0;
      end else begin
         pending_q <= commit_wr | (pending_q & ~SAMPLE_TICK);
         done_q    <= commit | (done_q & ~done_clr);
         if (commit)
            glob_act <= glob_q;
      end
   end

   assign status         = {30'b0, done_q, pending_q};
   assign COMMIT_PENDING = pending_q;
`else
   logic unused_tick;
   assign unused_tick    = SAMPLE_TICK;
   assign commit         = 1'b0;
   assign glob_act       = glob_q;
   assign status         = '0;
   assign COMMIT_PENDING = 1'b0;
`endif

   voice_regs_t voice_sh  [NUM_VOICES];
   voice_regs_t voice_act [NUM_VOICES];

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      synth_voice_regbank u_bank (
         .CLK     (CLK),
         .RESET   (RESET),
         .wr_en   (wr && in_voice && (vrel[31:2] == 30'(v))),
         .wr_off  (vrel[1:0]),
         .wr_dat  (wdat),
         .byte_en (be),
         .commit  (commit),
         .shadow  (voice_sh[v]),
         .active  (voice_act[v])
      );

      assign KEY[v]  = voice_act[v].key;
      assign FREQ[v] = voice_act[v].freq;
      assign AMP1[v] = voice_act[v].amp1;
      assign AMP0[v] = voice_act[v].amp0;
   end

   assign SHAPE1      = glob_act.shape1;
   assign SHAPE0      = glob_act.shape0;
   assign ATTACK      = glob_act.attack;
   assign DECAY       = glob_act.decay;
   assign SUSTAIN     = glob_act.sustain;
   assign RLEASE      = glob_act.rlease;
   assign GLIDE_EN    = glob_act.glide_en;
   assign GLIDE_RATE  = glob_act.glide_rate;
   assign ARP_EN      = glob_act.arp_en;
   assign ARP_TIME    = glob_act.arp_time;
   assign PINGPONG_EN = glob_act.pingpong_en;
   assign PANNING     = glob_act.panning;

   logic [31:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      case (addr32)
         REG_SHAPE1:      rd_mux = 32'(glob_q.shape1);
         REG_SHAPE0:      rd_mux = 32'(glob_q.shape0);
         REG_ATTACK:      rd_mux = 32'(glob_q.attack);
         REG_DECAY:       rd_mux = 32'(glob_q.decay);
         REG_SUSTAIN:     rd_mux = 32'(glob_q.sustain);
         REG_RLEASE:      rd_mux = 32'(glob_q.rlease);
         REG_GLIDE_EN:    rd_mux = 32'(glob_q.glide_en);
         REG_GLIDE_RATE:  rd_mux = 32'(glob_q.glide_rate);
         REG_ARP_EN:      rd_mux = 32'(glob_q.arp_en);
         REG_ARP_TIME:    rd_mux = 32'(glob_q.arp_time);
         REG_PINGPONG_EN: rd_mux = 32'(glob_q.pingpong_en);
         REG_PANNING:     rd_mux = 32'(glob_q.panning);
         REG_STATUS:      rd_mux = status;
         REG_VERSION:     rd_mux = VERSION;
         default:         ;
      endcase
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (in_voice && (vrel[31:2] == 30'(v))) begin
            case (int'(vrel[1:0]))
               VOFF_KEY:  rd_mux = 32'(voice_sh[v].key);
               VOFF_FREQ: rd_mux = 32'(voice_sh[v].freq);
               VOFF_AMP1: rd_mux = 32'(voice_sh[v].amp1);
               VOFF_AMP0: rd_mux = 32'(voice_sh[v].amp0);
               default:   ;
            endcase
         end
      end
   end

   logic [31:0] rdata_q;
   logic        rvld_q;

   // Data is forced to 0 on idle cycles so the bus never carries stale values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rdata_q <= '0;
         rvld_q  <= 1'b0;
      end else begin
         rvld_q  <= rd;
         rdata_q <= rd ? rd_mux : '0;
      end
   end

   assign avl.AVL_READDATA      = rdata_q;
   assign avl.AVL_READDATAVALID = rvld_q;

endmodule

// File: tb/tb_synth_ctrl_regs.sv
// Directed bench for synth_ctrl_regs with an address-indexed reference model checked every cycle.
module tb_synth_ctrl_regs;

   localparam int NV = 8;
   localparam int AW = 7;
`ifdef SYNTH_CTRL_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RESET;
   logic SAMPLE_TICK;
   logic [1:0]          SHAPE1, SHAPE0;
   logic [15:0]         ATTACK, DECAY, SUSTAIN, RLEASE;
   logic                GLIDE_EN;
   logic [24:0]         GLIDE_RATE;
   logic                ARP_EN;
   logic [15:0]         ARP_TIME;
   logic                PINGPONG_EN;
   logic [15:0]         PANNING;
   logic [NV-1:0]       KEY;
   logic [NV-1:0][6:0]  FREQ;
   logic [NV-1:0][15:0] AMP1, AMP0;
   logic                COMMIT_PENDING;

   synth_ctrl_regs_if #(.ADDR_W(AW)) avl ();

   synth_ctrl_regs #(.NUM_VOICES(NV), .ADDR_W(AW)) dut (
      .CLK(CLK), .RESET(RESET), .avl(avl), .SAMPLE_TICK(SAMPLE_TICK),
      .SHAPE1(SHAPE1), .SHAPE0(SHAPE0), .ATTACK(ATTACK), .DECAY(DECAY),
      .SUSTAIN(SUSTAIN), .RLEASE(RLEASE), .GLIDE_EN(GLIDE_EN), .GLIDE_RATE(GLIDE_RATE),
      .ARP_EN(ARP_EN), .ARP_TIME(ARP_TIME), .PINGPONG_EN(PINGPONG_EN), .PANNING(PANNING),
      .KEY(KEY), .FREQ(FREQ), .AMP1(AMP1), .AMP0(AMP0), .COMMIT_PENDING(COMMIT_PENDING)
   );

   always #5 CLK = ~CLK;

   // Reference model: one word per bus address.
   logic [31:0] m_sh  [128];
   logic [31:0] m_act [128];
   bit          m_pend, m_done;
   bit          exp_vld;
   logic [31:0] exp_dat;
   int          checks = 0;
   int          failures = 0;
   bit          cmp_en = 1'b0;

   function automatic logic [31:0] fmask(int a);
      if (a == 0 || a == 1) return 32'h3;
      if (a >= 2 && a <= 5) return 32'hFFFF;
      if (a == 6 || a == 8 || a == 10) return 32'h1;
      if (a == 7) return 32'h1FF_FFFF;
      if (a == 9 || a == 11) return 32'hFFFF;
      if (a >= 32 && a < 32 + 4 * NV) begin
         case ((a - 32) % 4)
            0: return 32'h1;
            1: return 32'h7F;
            default: return 32'hFFFF;
         endcase
      end
      return 32'h0;
   endfunction

   function automatic logic [31:0] model_read(int a);
      if (fmask(a) != 0) return m_sh[a];
      if (a == 13 && SHADOW) return 32'((int'(m_done) << 1) | int'(m_pend));
      if (a == 14) return 32'h0002_0000 | 32'(NV);
      return 32'h0;
   endfunction

   function automatic logic [31:0] dut_glob(int a);
      case (a)
         0: return 32'(SHAPE1);       1: return 32'(SHAPE0);
         2: return 32'(ATTACK);       3: return 32'(DECAY);
         4: return 32'(SUSTAIN);      5: return 32'(RLEASE);
         6: return 32'(GLIDE_EN);     7: return 32'(GLIDE_RATE);
         8: return 32'(ARP_EN);       9: return 32'(ARP_TIME);
         10: return 32'(PINGPONG_EN); 11: return 32'(PANNING);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] dut_voice(int v, int k);
      case (k)
         0: return 32'(KEY[v]);
         1: return 32'(FREQ[v]);
         2: return 32'(AMP1[v]);
         default: return 32'(AMP0[v]);
      endcase
   endfunction

   task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] actual=0x%08h required=0x%08h", nm, idx, act, exp);
      end
   endtask

   // Apply one bus cycle, then advance the model by the rules of the register map.
   task automatic step(bit rst, bit cs, bit rd, bit wr, int a, logic [3:0] be, logic [31:0] wd, bit tick);
      bit          fire, wre, cset, dclr;
      logic [31:0] nv;
      RESET = rst; avl.AVL_CS = cs; avl.AVL_READ = rd; avl.AVL_WRITE = wr;
      avl.AVL_ADDR = AW'(a); avl.AVL_BYTE_EN = be; avl.AVL_WRITEDATA = wd; SAMPLE_TICK = tick;
      @(posedge CLK);
      #1;
      if (rst) begin
         for (int i = 0; i < 128; i++) begin m_sh[i] = 0; m_act[i] = 0; end
         m_pend = 0; m_done = 0; exp_vld = 0; exp_dat = 0;
      end else begin
         fire    = SHADOW && tick && m_pend;
         wre     = cs && wr;
         exp_vld = cs && rd;
         exp_dat = exp_vld ? model_read(a) : 32'h0;
         if (fire) m_act = m_sh;
         if (wre && fmask(a) != 0) begin
            nv = m_sh[a];
            for (int b = 0; b < 4; b++) if (be[b]) nv[8*b +: 8] = wd[8*b +: 8];
            m_sh[a] = nv & fmask(a);
            if (!SHADOW) m_act[a] = m_sh[a];
         end
         if (SHADOW) begin
            cset   = wre && a == 12 && be[0] && wd[0];
            dclr   = wre && a == 13 && be[0] && wd[1];
            m_done = fire || (m_done && !dclr);
            m_pend = cset || (m_pend && !fire);
         end
      end
   endtask

   task automatic idle(); step(0, 0, 0, 0, 0, 4'h0, 32'h0, 0); endtask
   task automatic wr_reg(int a, logic [3:0] be, logic [31:0] d); step(0, 1, 0, 1, a, be, d, 0); endtask
   task automatic tick(); step(0, 0, 0, 0, 0, 4'h0, 32'h0, 1); endtask

   task automatic rd_lit(string nm, int a, logic [31:0] exp);
      step(0, 1, 1, 0, a, 4'h0, 32'h0, 0);
      @(negedge CLK);
      chk(nm, a, avl.AVL_READDATA, exp);
   endtask

   task automatic out_lit(string nm, logic [31:0] act, logic [31:0] exp);
      @(negedge CLK);
      chk(nm, 0, act, exp);
   endtask

   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("rvalid", 0, 32'(avl.AVL_READDATAVALID), 32'(exp_vld));
         chk("rdata", 0, avl.AVL_READDATA, exp_dat);
         chk("pending", 0, 32'(COMMIT_PENDING), 32'(SHADOW && m_pend));
         for (int a = 0; a < 12; a++) chk("glob_out", a, dut_glob(a), m_act[a]);
         for (int v = 0; v < NV; v++)
            for (int k = 0; k < 4; k++) chk("voice_out", 4 * v + k, dut_voice(v, k), m_act[32 + 4 * v + k]);
      end
   end

   initial begin
      RESET = 1; SAMPLE_TICK = 0;
      avl.AVL_CS = 0; avl.AVL_READ = 0; avl.AVL_WRITE = 0;
      avl.AVL_ADDR = '0; avl.AVL_BYTE_EN = '0; avl.AVL_WRITEDATA = '0;
      step(1, 0, 0, 0, 0, 4'h0, 32'h0, 0);
      step(1, 0, 0, 0, 0, 4'h0, 32'h0, 0);
      cmp_en = 1;

      for (int a = 0; a < 64; a++) step(0, 1, 1, 0, a, 4'h0, 32'h0, 0);
      rd_lit("version_lit", 14, 32'h0002_0008);
      rd_lit("commit_reads0", 12, 32'h0);

      wr_reg(31, 4'hF, 32'hFFFF_FFFF);
      wr_reg(32 + 4 * NV, 4'hF, 32'hFFFF_FFFF);
      rd_lit("unmapped31", 31, 32'h0);
      rd_lit("beyond_voices", 32 + 4 * NV, 32'h0);

      wr_reg(2, 4'b0001, 32'h1234);
      rd_lit("attack_shadow", 2, 32'h34);
      wr_reg(45, 4'hF, 32'h1C5);
      rd_lit("freq3_masked", 45, 32'h45);

      if (SHADOW) begin
         out_lit("attack_pre_commit", 32'(ATTACK), 32'h0);
         wr_reg(12, 4'b0001, 32'h1);
         out_lit("pending_set", 32'(COMMIT_PENDING), 32'h1);
         tick();
         out_lit("attack_committed", 32'(ATTACK), 32'h34);
         rd_lit("status_done", 13, 32'h2);

         wr_reg(12, 4'b0001, 32'h1);
         step(0, 1, 0, 1, 45, 4'hF, 32'h50, 1);
         out_lit("freq3_prewrite", 32'(FREQ[3]), 32'h45);
         rd_lit("freq3_shadow", 45, 32'h50);
         wr_reg(12, 4'b0001, 32'h1);
         tick();
         out_lit("freq3_second", 32'(FREQ[3]), 32'h50);

         wr_reg(3, 4'hF, 32'hBEEF);
         wr_reg(12, 4'b0001, 32'h1);
         step(1, 0, 0, 0, 0, 4'h0, 32'h0, 0);
         out_lit("pending_after_rst", 32'(COMMIT_PENDING), 32'h0);
         tick();
         out_lit("decay_after_rst", 32'(DECAY), 32'h0);
         out_lit("freq3_after_rst", 32'(FREQ[3]), 32'h0);

         step(0, 1, 0, 1, 12, 4'b0001, 32'h1, 1);
         out_lit("pending_tick_cycle", 32'(COMMIT_PENDING), 32'h1);
         step(0, 1, 0, 1, 13, 4'b0001, 32'h2, 1);
         rd_lit("status_set_wins", 13, 32'h2);
         wr_reg(13, 4'b0001, 32'h2);
         rd_lit("status_cleared", 13, 32'h0);
      end else begin
         out_lit("attack_direct", 32'(ATTACK), 32'h34);
         out_lit("freq3_direct", 32'(FREQ[3]), 32'h45);
         wr_reg(32, 4'b0001, 32'h1);
         out_lit("key0_direct", 32'(KEY[0]), 32'h1);
         wr_reg(12, 4'b0001, 32'h1);
         out_lit("no_pending", 32'(COMMIT_PENDING), 32'h0);
         rd_lit("status_zero", 13, 32'h0);
      end

      // Same-address read and write must return the old value.
      step(0, 1, 1, 1, 9, 4'hF, 32'hA5A5, 0);
      idle();

      for (int i = 0; i < 250; i++) begin
         int a;
         int sel;
         sel = $urandom_range(0, 3);
         case (sel)
            0: a = $urandom_range(0, 14);
            1: a = $urandom_range(32, 32 + 4 * NV - 1);
            2: a = $urandom_range(12, 13);
            default: a = $urandom_range(0, 127);
         endcase
         step(0, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              a, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 3) == 0));
      end
      tick();
      for (int a = 0; a < 128; a++) step(0, 1, 1, 0, a, 4'h0, 32'h0, 0);
      idle();
      @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
